pipeline_id_stage: RTL and testbench
====================================

Name: pipeline_id_stage

Overview:
Parametrised instruction-decode stage with an integrated ID/EX pipeline register. It contains:
- the register file, with write-through bypass from WB;
- sign/zero extension;
- load-use hazard detection, which stalls IF and inserts a bubble;
- flush and downstream-hold handling.

It sits between the IF/ID register and the EX stage. It consumes the control word from the main decoder and presents registered operands and controls to EX.

Parameters:
DATA_W, 32, datapath and register width
REG_ADDR_W, 5, register address width; NUM_REGS = 2**REG_ADDR_W
LINK_REG, 31, destination register forced when link=1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  IF/ID holds a real instruction
id_pc  in  DATA_W  PC of the ID instruction
id_instr  in  32  instruction word
id_ctrl  in  CTRL_W  decoded control word (layout in package)
wb_we  in  1  register write enable from WB
wb_addr  in  REG_ADDR_W  WB destination register
wb_data  in  DATA_W  WB write data
ex_flush  in  1  branch/jump resolved taken in EX; kill the ID instruction
ex_hold  in  1  downstream stall; freeze the ID/EX register
if_stall  out  1  hold PC and IF/ID (combinational)
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  DATA_W  registered PC
ex_ctrl  out  CTRL_W  registered control word; all zero for a bubble
ex_rs, ex_rt, ex_dst  out  REG_ADDR_W  source and resolved destination registers
ex_rdata_a, ex_rdata_b  out  DATA_W  register operands
ex_imm  out  DATA_W  extended immediate
ex_funct  out  6  instr[5:0]

Behaviour:
- Reset: all ex_* outputs are 0 and if_stall is 0. Register file contents are cleared to 0 over a single reset cycle.
- Register file:
  - NUM_REGS x DATA_W, written on the rising edge when wb_we=1 and wb_addr!=0.
  - Register 0 reads as 0.
  - Bypass: if wb_we, wb_addr!=0 and wb_addr equals the read address, the read returns wb_data in the same cycle.
- Field decode: rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], each zero-extended or truncated to REG_ADDR_W.
- Destination: dst = LINK_REG if link; else rd if regdst; else rt.
- Immediate:
  - signext=1: sign-extend instr[15:0].
  - signext=0: zero-extend instr[15:0].
  - shiftl16 is passed through only; it is not applied here.
- Source usage:
  - uses_rs = !(jump && !jumptoreg).
  - uses_rt = !alusrc || memwrite || branch.
- Load-use hazard (hz): all of the following hold:
  - ex_valid, ex_ctrl.memtoreg and ex_ctrl.regwrite are set;
  - ex_dst != 0;
  - (uses_rs && ex_dst == rs) or (uses_rt && ex_dst == rt);
  - id_valid is set.
- Next-state priority for the ID/EX register, highest first:
  1. reset: all zero.
  2. ex_flush: bubble (ex_valid=0, ex_ctrl=0; data fields don't-care but deterministic 0).
  3. ex_hold: hold all ex_* unchanged.
  4. hz: bubble.
  5. Otherwise: load ID values; ex_valid = id_valid; ex_ctrl = id_valid ? id_ctrl : 0.
- if_stall = hz && !ex_flush, OR ex_hold && !ex_flush.
  - Flush always releases the stall, so the fetcher redirects.
- A load-use stall lasts exactly one cycle: the load leaves EX and the dependent instruction then issues. The EX→ID forwarding that follows is owned by the EX stage.
- Simultaneous WB write and a hazard stall: the bypass still applies on the cycle the instruction finally issues.
- Reset asserted mid-stall: stall drops on the next cycle; no bubble carries over.

Optional Feature:
ID_PERF_CNT_EN:
- Defined:
  - Adds outputs perf_stall_cnt [31:0] (counts cycles with hz && !ex_flush && !ex_hold) and perf_flush_cnt [31:0] (counts cycles with ex_flush && id_valid).
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the ports and logic are absent.

Decomposition:
- Package pipeline_pkg holds:
  - CTRL_W = 14;
  - bit indices CTRL_REGWRITE=0, MEMTOREG=1, MEMWRITE=2, BRANCH=3, ALUSRC=4, REGDST=5, JUMP=6, LINK=7, NEZ=8, JUMPTOREG=9, SHIFTL16=10, SIGNEXT=11, ALUOP=13:12.
- Sub-module id_regfile (parameters DATA_W, REG_ADDR_W):
  - two read ports with WB bypass;
  - one write port;
  - synchronous clear.

Test Plan:
- Reset then WB write: write reg 5 = 0x1234_5678, then decode add rs=5 → ex_rdata_a = 0x1234_5678 the next cycle. Write to reg 0 → reads 0.
- Bypass: wb_we=1, wb_addr=8, wb_data=0xDEAD_BEEF in the same cycle as an instruction reading rt=8 → ex_rdata_b = 0xDEAD_BEEF.
- Load-use: lw $9 in EX, then add with rs=9 in ID → if_stall=1 for 1 cycle, one bubble (ex_valid=0, ex_ctrl=0), then the add issues. The same sequence with an addi using only rt=9 as destination → no stall.
- Flush: ex_flush=1 together with hz=1 → if_stall=0, bubble inserted, perf_flush_cnt increments by 1 when ID_PERF_CNT_EN is defined.
- Hold: ex_hold=1 for 3 cycles while ID changes → ex_* stay constant and if_stall=1. Release → the held ID instruction loads.
- Immediate and link: 0xFFFF with signext=1 → 0xFFFF_FFFF; with signext=0 → 0x0000_FFFF. jal (link=1) → ex_dst = 31.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared definitions for the pipeline ID stage: control-word
//                width and bit positions, plus the MIPS-style instruction
//                field layout used when decoding register specifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Control word produced by the main decoder.
  localparam int CTRL_W         = 14;
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_REGDST    = 5;
  localparam int CTRL_JUMP      = 6;
  localparam int CTRL_LINK      = 7;
  localparam int CTRL_NEZ       = 8;
  localparam int CTRL_JUMPTOREG = 9;
  localparam int CTRL_SHIFTL16  = 10;
  localparam int CTRL_SIGNEXT   = 11;
  localparam int CTRL_ALUOP_LO  = 12;
  localparam int CTRL_ALUOP_HI  = 13;

  // Fixed 32-bit instruction layout. The low 16 bits double as the
  // immediate for I-type instructions.
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_fields_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/id_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : id_regfile
//  Description : NUM_REGS x DATA_W register file, two combinational read
//                ports with write-through bypass from WB, one write port,
//                single-cycle synchronous clear. Register 0 reads as zero.
//  Ports       : clk, i_rst                - clock / sync active-high clear
//                i_raddr_a/b, o_rdata_a/b  - read ports
//                i_we, i_waddr, i_wdata    - write port (from WB)
//  Revision    : 1.0 - initial release
// ============================================================================
module id_regfile #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_raddr_a,
  input  logic [REG_ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0]     o_rdata_a,
  output logic [DATA_W-1:0]     o_rdata_b,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_wr_en;

  assign w_wr_en = i_we && (i_waddr != '0);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Write-through: a same-cycle WB write to the register being read wins,
  // so ID never sees a stale value while WB is retiring into it.
  always_comb begin
    o_rdata_a = r_mem[i_raddr_a];
    if (i_raddr_a == '0) begin
      o_rdata_a = '0;
    end else if (w_wr_en && (i_waddr == i_raddr_a)) begin
      o_rdata_a = i_wdata;
    end
  end

  always_comb begin
    o_rdata_b = r_mem[i_raddr_b];
    if (i_raddr_b == '0) begin
      o_rdata_b = '0;
    end else if (w_wr_en && (i_waddr == i_raddr_b)) begin
      o_rdata_b = i_wdata;
    end
  end

endmodule : id_regfile
`default_nettype wire

// File: rtl/pipeline_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_id_stage
//  Description : Instruction-decode stage with integrated ID/EX register.
//                Register read with WB bypass, immediate extension,
//                destination resolution, load-use hazard detection (stalls
//                IF and inserts a bubble), flush and downstream-hold handling.
//  Options     : `define ID_PERF_CNT_EN adds saturating perf_stall_cnt and
//                perf_flush_cnt outputs.
//  Ports       : clk, reset                       - clock / sync reset
//                id_valid, id_pc, id_instr, id_ctrl - instruction in ID
//                wb_we, wb_addr, wb_data           - register write from WB
//                ex_flush, ex_hold                 - EX kill / downstream stall
//                if_stall                          - hold PC and IF/ID
//                ex_*                              - ID/EX register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_id_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [31:0]           id_instr,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_flush,
  input  logic                  ex_hold,
  output logic                  if_stall,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic [DATA_W-1:0]     ex_rdata_a,
  output logic [DATA_W-1:0]     ex_rdata_b,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [5:0]            ex_funct
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Field decode
  // --------------------------------------------------------------------------
  instr_fields_t         w_f;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [REG_ADDR_W-1:0] w_dst;
  logic [DATA_W-1:0]     w_imm;
  logic [DATA_W-1:0]     w_rdata_a;
  logic [DATA_W-1:0]     w_rdata_b;
  logic                  w_unused_bits;

  assign w_f  = id_instr;
  assign w_rs = REG_ADDR_W'(w_f.rs);
  assign w_rt = REG_ADDR_W'(w_f.rt);
  assign w_rd = REG_ADDR_W'(w_f.rd);

  // Opcode and shamt are consumed by the main decoder, not here.
  assign w_unused_bits = ^{w_f.op, w_f.shamt};

  always_comb begin
    w_dst = w_rt;
    if (id_ctrl[CTRL_LINK]) begin
      w_dst = REG_ADDR_W'(LINK_REG);
    end else if (id_ctrl[CTRL_REGDST]) begin
      w_dst = w_rd;
    end
  end

  // shiftl16 travels with the control word; the shift happens in EX.
  assign w_imm = id_ctrl[CTRL_SIGNEXT] ? DATA_W'($signed(id_instr[15:0]))
                                       : DATA_W'(id_instr[15:0]);

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  id_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .i_rst     (reset),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b),
    .i_we      (wb_we),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data)
  );

  // --------------------------------------------------------------------------
  // Load-use hazard
  // --------------------------------------------------------------------------
  logic r_ex_valid;
  logic [DATA_W-1:0]     r_ex_pc;
  logic [CTRL_W-1:0]     r_ex_ctrl;
  logic [REG_ADDR_W-1:0] r_ex_rs;
  logic [REG_ADDR_W-1:0] r_ex_rt;
  logic [REG_ADDR_W-1:0] r_ex_dst;
  logic [DATA_W-1:0]     r_ex_rdata_a;
  logic [DATA_W-1:0]     r_ex_rdata_b;
  logic [DATA_W-1:0]     r_ex_imm;
  logic [5:0]            r_ex_funct;

  logic w_uses_rs;
  logic w_uses_rt;
  logic w_ex_is_load;
  logic w_hz;

  // A direct jump has no register source; jr/jalr does.
  assign w_uses_rs = !(id_ctrl[CTRL_JUMP] && !id_ctrl[CTRL_JUMPTOREG]);
  // rt is a source for R-type, stores (data) and branches (compare).
  assign w_uses_rt = !id_ctrl[CTRL_ALUSRC] || id_ctrl[CTRL_MEMWRITE]
                     || id_ctrl[CTRL_BRANCH];

  assign w_ex_is_load = r_ex_valid && r_ex_ctrl[CTRL_MEMTOREG]
                        && r_ex_ctrl[CTRL_REGWRITE] && (r_ex_dst != '0);

  assign w_hz = id_valid && w_ex_is_load
                && ((w_uses_rs && (r_ex_dst == w_rs))
                 || (w_uses_rt && (r_ex_dst == w_rt)));

  // Flush overrides every stall so the fetcher can redirect immediately.
  assign if_stall = (w_hz || ex_hold) && !ex_flush;

  // --------------------------------------------------------------------------
  // ID/EX register
  // --------------------------------------------------------------------------
  logic w_upd;
  logic w_load;

  // The register updates unless held; a flush updates it even while held.
  assign w_upd  = ex_flush || !ex_hold;
  // Anything that is not a real load into EX becomes an all-zero bubble.
  assign w_load = !ex_flush && !w_hz;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid   <= 1'b0;
      r_ex_pc      <= '0;
      r_ex_ctrl    <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_dst     <= '0;
      r_ex_rdata_a <= '0;
      r_ex_rdata_b <= '0;
      r_ex_imm     <= '0;
      r_ex_funct   <= '0;
    end else if (w_upd) begin
      r_ex_valid   <= w_load && id_valid;
      r_ex_pc      <= w_load ? id_pc : '0;
      r_ex_ctrl    <= (w_load && id_valid) ? id_ctrl : '0;
      r_ex_rs      <= w_load ? w_rs : '0;
      r_ex_rt      <= w_load ? w_rt : '0;
      r_ex_dst     <= w_load ? w_dst : '0;
      r_ex_rdata_a <= w_load ? w_rdata_a : '0;
      r_ex_rdata_b <= w_load ? w_rdata_b : '0;
      r_ex_imm     <= w_load ? w_imm : '0;
      r_ex_funct   <= w_load ? w_f.funct : '0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_pc      = r_ex_pc;
  assign ex_ctrl    = r_ex_ctrl;
  assign ex_rs      = r_ex_rs;
  assign ex_rt      = r_ex_rt;
  assign ex_dst     = r_ex_dst;
  assign ex_rdata_a = r_ex_rdata_a;
  assign ex_rdata_b = r_ex_rdata_b;
  assign ex_imm     = r_ex_imm;
  assign ex_funct   = r_ex_funct;

`ifdef ID_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hz && !ex_flush && !ex_hold && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (ex_flush && id_valid && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule : pipeline_id_stage
`default_nettype wire

// File: tb/tb_pipeline_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_id_stage
//  Description : Self-checking bench for pipeline_id_stage: directed cases
//                for the main scenarios followed by randomized traffic,
//                all compared against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_id_stage;
  import pipeline_pkg::*;

  localparam logic [13:0] C_ADD  = 14'((1 << CTRL_REGWRITE) | (1 << CTRL_REGDST));
  localparam logic [13:0] C_LW   = 14'((1 << CTRL_REGWRITE) | (1 << CTRL_MEMTOREG)
                                     | (1 << CTRL_ALUSRC) | (1 << CTRL_SIGNEXT));
  localparam logic [13:0] C_ADDI = 14'((1 << CTRL_REGWRITE) | (1 << CTRL_ALUSRC)
                                     | (1 << CTRL_SIGNEXT));
  localparam logic [13:0] C_ORI  = 14'((1 << CTRL_REGWRITE) | (1 << CTRL_ALUSRC));
  localparam logic [13:0] C_JAL  = 14'((1 << CTRL_REGWRITE) | (1 << CTRL_JUMP)
                                     | (1 << CTRL_LINK));

  logic        clk = 1'b0;
  logic        reset, id_valid, wb_we, ex_flush, ex_hold;
  logic [31:0] id_pc, id_instr, wb_data;
  logic [13:0] id_ctrl;
  logic [4:0]  wb_addr;
  logic        if_stall, ex_valid;
  logic [31:0] ex_pc, ex_rdata_a, ex_rdata_b, ex_imm;
  logic [13:0] ex_ctrl;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [5:0]  ex_funct;
`ifdef ID_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_id_stage dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_ctrl    (id_ctrl),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ex_flush   (ex_flush),
    .ex_hold    (ex_hold),
    .if_stall   (if_stall),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .ex_ctrl    (ex_ctrl),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_dst     (ex_dst),
    .ex_rdata_a (ex_rdata_a),
    .ex_rdata_b (ex_rdata_b),
    .ex_imm     (ex_imm),
    .ex_funct   (ex_funct)
`ifdef ID_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_pc, m_a, m_b, m_imm;
  logic [13:0] m_ctrl;
  logic [4:0]  m_rs, m_rt, m_dst;
  logic [5:0]  m_funct;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bit model_hz();
    logic [4:0] rs, rt;
    bit urs, urt;
    rs  = id_instr[25:21];
    rt  = id_instr[20:16];
    urs = !(id_ctrl[CTRL_JUMP] && !id_ctrl[CTRL_JUMPTOREG]);
    urt = !id_ctrl[CTRL_ALUSRC] || id_ctrl[CTRL_MEMWRITE] || id_ctrl[CTRL_BRANCH];
    return id_valid && m_valid && m_ctrl[CTRL_MEMTOREG] && m_ctrl[CTRL_REGWRITE]
           && m_dst != 5'd0 && ((urs && m_dst == rs) || (urt && m_dst == rt));
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_pc = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_dst = 0;
    m_a = 0; m_b = 0; m_imm = 0; m_funct = 0;
  endtask

  task automatic model_clock(input bit hz);
    if (reset) begin
      model_bubble();
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      return;
    end
    if (hz && !ex_flush && !ex_hold && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (ex_flush && id_valid && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    if (ex_flush || (!ex_hold && hz)) begin
      model_bubble();
    end else if (!ex_hold) begin
      m_valid = id_valid;
      m_pc    = id_pc;
      m_ctrl  = id_valid ? id_ctrl : 14'd0;
      m_rs    = id_instr[25:21];
      m_rt    = id_instr[20:16];
      m_dst   = id_ctrl[CTRL_LINK] ? 5'd31 :
                id_ctrl[CTRL_REGDST] ? id_instr[15:11] : id_instr[20:16];
      m_a     = rf_read(m_rs);
      m_b     = rf_read(m_rt);
      m_imm   = id_ctrl[CTRL_SIGNEXT] ? {{16{id_instr[15]}}, id_instr[15:0]}
                                      : {16'd0, id_instr[15:0]};
      m_funct = id_instr[5:0];
    end
    if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
  endtask

  // One clock: check the combinational stall, clock, check ID/EX contents.
  task automatic tick();
    bit hz;
    #1;
    hz = model_hz();
    if (!reset) chk("if_stall", if_stall, (hz || ex_hold) && !ex_flush);
    @(posedge clk);
    model_clock(hz);
    #1;
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_ctrl", ex_ctrl, m_ctrl);
    chk("ex_rs", ex_rs, m_rs);
    chk("ex_rt", ex_rt, m_rt);
    chk("ex_dst", ex_dst, m_dst);
    chk("ex_rdata_a", ex_rdata_a, m_a);
    chk("ex_rdata_b", ex_rdata_b, m_b);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_funct", ex_funct, m_funct);
`ifdef ID_PERF_CNT_EN
    chk("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
    chk("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif
  endtask

  task automatic idle();
    reset = 0; id_valid = 0; id_pc = 0; id_instr = 0; id_ctrl = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; ex_flush = 0; ex_hold = 0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [13:0] ctrl);
    id_valid = 1;
    id_instr = instr;
    id_ctrl  = ctrl;
    id_pc    = id_pc + 32'd4;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    logic [4:0] rrs, rrt, rrd;
    idle();
    model_bubble();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'hX;
    m_stall_cnt = 0;
    m_flush_cnt = 0;

    // Reset
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_if_stall", if_stall, 0);

    // WB write then read
    wb_we = 1; wb_addr = 5; wb_data = 32'h1234_5678;
    tick();
    wb_we = 0;
    issue(r_type(5, 0, 3), C_ADD);
    tick();
    chk("wb_then_read", ex_rdata_a, 32'h1234_5678);

    // Write to r0 is ignored
    id_valid = 0;
    wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    tick();
    wb_we = 0;
    issue(r_type(0, 0, 3), C_ADD);
    tick();
    chk("r0_reads_zero", ex_rdata_a, 0);

    // Same-cycle bypass
    wb_we = 1; wb_addr = 8; wb_data = 32'hDEAD_BEEF;
    issue(r_type(1, 8, 4), C_ADD);
    tick();
    wb_we = 0;
    chk("bypass_rt", ex_rdata_b, 32'hDEAD_BEEF);

    // Load-use: one stall cycle, one bubble, then issue
    issue(i_type(6'h23, 1, 9, 16'd4), C_LW);
    tick();
    issue(r_type(9, 2, 4), C_ADD);
    #1 chk("lu_stall", if_stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctrl", ex_ctrl, 0);
    #1 chk("lu_release", if_stall, 0);
    tick();
    chk("lu_issue", ex_valid, 1);

    // addi writing the loaded register does not depend on it
    issue(i_type(6'h23, 1, 9, 16'd4), C_LW);
    tick();
    issue(i_type(6'h08, 2, 9, 16'd5), C_ADDI);
    #1 chk("addi_no_stall", if_stall, 0);
    tick();

    // Flush together with a hazard
    issue(i_type(6'h23, 1, 9, 16'd4), C_LW);
    tick();
    issue(r_type(9, 2, 4), C_ADD);
    ex_flush = 1;
    #1 chk("flush_no_stall", if_stall, 0);
    tick();
    ex_flush = 0;
    chk("flush_bubble", ex_valid, 0);

    // Hold for three cycles while ID changes
    issue(r_type(3, 4, 5), C_ADD);
    tick();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      issue(r_type(5'(i + 10), 6, 7), C_ADD);
      #1 chk("hold_stall", if_stall, 1);
      tick();
      chk("hold_rs", ex_rs, 3);
    end
    ex_hold = 0;
    tick();
    chk("hold_release", ex_rs, 12);

    // Immediate extension and link
    issue(i_type(6'h08, 0, 1, 16'hFFFF), C_ADDI);
    tick();
    chk("imm_sext", ex_imm, 32'hFFFF_FFFF);
    issue(i_type(6'h0D, 0, 1, 16'hFFFF), C_ORI);
    tick();
    chk("imm_zext", ex_imm, 32'h0000_FFFF);
    issue({6'h03, 26'h123}, C_JAL);
    tick();
    chk("jal_dst", ex_dst, 31);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_pc    = $urandom;
      rrs      = 5'($urandom_range(0, 7));
      rrt      = 5'($urandom_range(0, 7));
      rrd      = 5'($urandom_range(0, 7));
      id_instr = {6'($urandom), rrs, rrt, rrd, 11'($urandom)};
      id_ctrl  = 14'($urandom);
      if ($urandom_range(0, 4) < 2) id_ctrl = id_ctrl | 14'h0003;
      wb_we    = 1'($urandom);
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      ex_flush = ($urandom_range(0, 9) == 0);
      ex_hold  = ($urandom_range(0, 6) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipeline_id_stage
`default_nettype wire
